// File: rtl/cordic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_pkg : shared CORDIC constants, mode codes and FSM state type
// Revision   : 1.0
// ---------------------------------------------------------------------------
package cordic_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 16;
  localparam int DEF_ITER  = 16;

  localparam logic [1:0] MODE_CIRCULAR = 2'd0;
  localparam logic [1:0] MODE_LINEAR   = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_atan_rom : combinational atan(2^-i), rounded to nearest in Q.FRAC
// Revision        : 1.0
// ---------------------------------------------------------------------------
module cordic_atan_rom #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int IW    = 5
) (
  input  logic [IW-1:0]    i,
  output logic [WIDTH-1:0] atan
);

  // Table is held in Q30, so FRAC must not exceed 29.
  localparam logic [63:0] RND = 64'd1 << (29 - FRAC);
  localparam int          SH  = 30 - FRAC;

  logic [63:0] q30;

  always_comb begin
    q30 = 64'd0;
    case (int'(i))
      0:  q30 = 64'h3243F6A8;
      1:  q30 = 64'h1DAC6705;
      2:  q30 = 64'h0FADBAFC;
      3:  q30 = 64'h07F56EA6;
      4:  q30 = 64'h03FEAB76;
      5:  q30 = 64'h01FFD55B;
      6:  q30 = 64'h00FFFAAA;
      7:  q30 = 64'h007FFF55;
      8:  q30 = 64'h003FFFEA;
      9:  q30 = 64'h001FFFFD;
      10: q30 = 64'h000FFFFF;
      default: begin
        // Beyond i=10 atan(2^-i) equals 2^-i to well under half a Q30 LSB.
        if (int'(i) <= 30) q30 = 64'd1 << (30 - int'(i));
      end
    endcase
    atan = WIDTH'((q30 + RND) >> SH);
  end

endmodule
`default_nettype wire

// File: rtl/cordic_rotate.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_rotate : iterative rotation-mode CORDIC (circular / linear), no gain fix
// Revision      : 1.0
// ---------------------------------------------------------------------------
module cordic_rotate
  import cordic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int ITER  = DEF_ITER
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] angle,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] rotated_x,
  output logic signed [WIDTH-1:0] rotated_y,
  output logic signed [WIDTH-1:0] final_angle
);

  localparam int             CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0]  LAST = CW'(ITER);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

  state_t                  state, state_nx;
  logic [CW-1:0]           iter;
  logic [1:0]              mode_r;
  logic signed [WIDTH-1:0] xr, yr, zr;
  logic signed [WIDTH-1:0] x_sh, y_sh, x_nx, y_nx, z_nx;
  logic signed [WIDTH-1:0] atan_val, lin_step;
  logic                    neg;

  cordic_atan_rom #(.WIDTH(WIDTH), .FRAC(FRAC), .IW(CW)) u_rom (
    .i    (iter),
    .atan (atan_val)
  );

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Single micro-rotation stage shared by every iteration.
  always_comb begin
    x_sh     = xr >>> iter;
    y_sh     = yr >>> iter;
    lin_step = ONE >> iter;
    neg      = zr[WIDTH-1];
    x_nx     = xr;
    y_nx     = yr;
    z_nx     = zr;
    case (mode_r)
      MODE_CIRCULAR: begin
        x_nx = neg ? xr + y_sh     : xr - y_sh;
        y_nx = neg ? yr - x_sh     : yr + x_sh;
        z_nx = neg ? zr + atan_val : zr - atan_val;
      end
      MODE_LINEAR: begin
        y_nx = neg ? yr - x_sh     : yr + x_sh;
        z_nx = neg ? zr + lin_step : zr - lin_step;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
      ST_RUN:           if (iter == LAST) state_nx = ST_DONE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      iter        <= '0;
      mode_r      <= MODE_CIRCULAR;
      xr          <= '0;
      yr          <= '0;
      zr          <= '0;
      rotated_x   <= '0;
      rotated_y   <= '0;
      final_angle <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            xr     <= x;
            yr     <= y;
            zr     <= angle;
            mode_r <= mode;
            iter   <= '0;
          end
        end
        ST_RUN: begin
          // ITER rotations, then one write-back cycle onto the outputs.
          if (iter != LAST) begin
            xr   <= x_nx;
            yr   <= y_nx;
            zr   <= z_nx;
            iter <= iter + 1'b1;
          end else begin
            rotated_x   <= xr;
            rotated_y   <= yr;
            final_angle <= zr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cordic_rotate.md
CORDIC_ROTATE -- requirements
Module: cordic_rotate

Interface
REQ-001 Parameter WIDTH, default 32: data width of x, y, angle and all results (two's complement).
REQ-002 Parameter FRAC, default 16: fractional bits; all operands and results are Q(WIDTH-FRAC).FRAC; angle is in radians.
REQ-003 Parameter ITER, default 16: number of micro-rotations per operation.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request pulse; sampled only when the block is not busy.
REQ-007 mode  input  2  CIRCULAR or LINEAR code from the shared constants file.
REQ-008 x, y  input  WIDTH  signed start vector, sampled with start.
REQ-009 angle  input  WIDTH  signed rotation amount z0, sampled with start.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse marking valid results.
REQ-012 rotated_x, rotated_y, final_angle  output  WIDTH  signed result vector and residual angle.

Function
REQ-013 The FSM shall have states IDLE, RUN and DONE; reset enters IDLE.
REQ-014 In IDLE or DONE, start=1 shall latch x, y, angle and mode, clear the iteration counter and enter RUN on the same edge.
REQ-015 In RUN, each clock performs exactly one micro-rotation i = 0..ITER-1, with d = +1 if z >= 0, else d = -1.
REQ-016 CIRCULAR: x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan(2^-i), with atan rounded to nearest in Q.FRAC.
REQ-017 LINEAR: x' = x; y' = y + d*(x>>>i); z' = z - d*2^-i.
REQ-018 Shifts shall be arithmetic; adds shall wrap modulo 2^WIDTH with no saturation.
REQ-019 Results shall not be gain-compensated: the circular magnitude grows by An ≈ 1.64676, and the caller pre-scales.
REQ-020 After iteration ITER-1 the FSM shall enter DONE, register the results onto the outputs, and assert done for exactly that one cycle.
REQ-021 Latency: with start sampled at edge N, done shall be high in the cycle following edge N+ITER+1.
REQ-022 busy shall be high in RUN and low in IDLE and DONE.
REQ-023 start while busy shall be ignored without corrupting the operation in flight.
REQ-024 Without a new start, DONE shall return to IDLE after one cycle; outputs hold their last result until the next done.
REQ-025 start asserted in the DONE cycle shall be accepted, giving back-to-back operations.
REQ-026 An unsupported mode code shall run the same latency with x, y and z left unchanged, so outputs equal the inputs.
REQ-027 Convergence ranges: |angle| <= 1.7433 rad in CIRCULAR and |angle| < 2.0 in LINEAR; behaviour outside these ranges is defined by REQ-015..018 only, with no error flag.

Reset
REQ-028 reset shall force IDLE, busy=0, done=0, rotated_x=rotated_y=final_angle=0, and clear the counter.
REQ-029 reset asserted mid-RUN shall abort the operation with no done pulse; reset has priority over start.

Structure
REQ-030 Mode codes, WIDTH, FRAC and ITER defaults shall live in the shared constants file used by the vectoring block.
REQ-031 The arctangent table shall be a sub-module cordic_atan_rom: input i, output atan(2^-i) in Q.FRAC, purely combinational.
REQ-032 The datapath shall use one shared add/shift stage, iterative rather than unrolled.

Verification
REQ-033 CIRCULAR, x=0x00010000, y=0, angle=0x0000C90F (pi/4) -> rotated_x ≈ rotated_y ≈ 0x00012A18 within ±8 LSB; final_angle within ±4 LSB of 0; done at N+ITER+1.
REQ-034 LINEAR, x=0x00020000, y=0, angle=0x00008000 -> rotated_y = 0x00010000 within ±4 LSB; rotated_x = 0x00020000 exactly.
REQ-035 A second start pulsed during RUN -> ignored; exactly one done; results match the first operation.
REQ-036 reset asserted at iteration 7 -> no done; all outputs 0; a following start completes normally.
REQ-037 start held high across the DONE cycle with new inputs -> second operation accepted; done pulses spaced ITER+2 cycles apart.
REQ-038 Round-trip check: the cordic_rotate output fed to the vectoring block returns the original angle within ±8 LSB, tested on 10 random in-range cases per mode.
